// File: rtl/hit_judge_multi.sv
// N-lane beat/hit judge: synchronises buttons and the beat window, judges each window's
// presses against the latched target mask and keeps a saturating combo counter.
module hit_judge_multi #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned TIMER_BITS     = 8,
  parameter int unsigned PERFECT_CYCLES = 16,
  parameter int unsigned COMBO_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  metronome_clk,
  input  logic [NUM_LANES-1:0]  btn,
  input  logic [NUM_LANES-1:0]  target,
  input  logic                  game_en,
  output logic                  correct_hit,
  output logic                  incorrect_hit,
  output logic                  partial,
  output logic [1:0]            grade,
  output logic                  judge_valid,
  output logic                  stray_press,
  output logic [COMBO_BITS-1:0] combo
);

  localparam logic [1:0] GRADE_NONE    = 2'd0;
  localparam logic [1:0] GRADE_PERFECT = 2'd1;
  localparam logic [1:0] GRADE_GOOD    = 2'd2;
  localparam logic [1:0] GRADE_MISS    = 2'd3;

  localparam logic [TIMER_BITS-1:0] TIMER_MAX = '1;
  localparam logic [COMBO_BITS-1:0] COMBO_MAX = '1;
  localparam logic [TIMER_BITS:0]   PERF_LIM  = (TIMER_BITS+1)'(PERFECT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DONE} state_t;

  state_t                r_state, w_state_n;
  logic [NUM_LANES-1:0]  r_btn_s1, r_btn_s2, r_btn_s3, r_btn_edge;
  logic                  r_win_s1, r_win_s2, r_win_s3, r_win_rise, r_win_fall;
  logic [TIMER_BITS-1:0] r_timer, w_timer_n, w_timer_cur;
  logic [NUM_LANES-1:0]  r_pressed, w_pressed_n, r_target_q, w_target_n;
  logic                  w_correct_n, w_incorrect_n, w_partial_n, w_valid_n, w_stray_n;
  logic [1:0]            w_grade_n;
  logic [COMBO_BITS-1:0] w_combo_n, w_combo_inc;
  logic                  w_eval, w_stray_edge;

  // Identical 3-flop synchronisers with registered edge detect keep all inputs aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_btn_s3   <= '0;
      r_btn_edge <= '0;
      r_win_s1   <= 1'b0;
      r_win_s2   <= 1'b0;
      r_win_s3   <= 1'b0;
      r_win_rise <= 1'b0;
      r_win_fall <= 1'b0;
    end else begin
      r_btn_s1   <= btn;
      r_btn_s2   <= r_btn_s1;
      r_btn_s3   <= r_btn_s2;
      r_btn_edge <= r_btn_s2 & ~r_btn_s3;
      r_win_s1   <= metronome_clk;
      r_win_s2   <= r_win_s1;
      r_win_s3   <= r_win_s2;
      r_win_rise <= r_win_s2 & ~r_win_s3;
      r_win_fall <= ~r_win_s2 & r_win_s3;
    end
  end

  assign w_combo_inc = (combo == COMBO_MAX) ? COMBO_MAX : combo + 1'b1;

  always_comb begin
    w_state_n     = r_state;
    w_timer_n     = r_timer;
    w_timer_cur   = r_timer;
    w_pressed_n   = r_pressed;
    w_target_n    = r_target_q;
    w_correct_n   = correct_hit;
    w_incorrect_n = incorrect_hit;
    w_partial_n   = partial;
    w_grade_n     = grade;
    w_valid_n     = 1'b0;
    w_stray_n     = 1'b0;
    w_combo_n     = combo;
    w_eval        = 1'b0;
    w_stray_edge  = 1'b0;

    if (game_en) begin
      if (r_state == S_IDLE) begin
        if (r_win_rise) begin
          // Window opens: clear first, so a same-cycle press is judged at timer 0.
          w_state_n     = S_OPEN;
          w_pressed_n   = '0;
          w_target_n    = target;
          w_correct_n   = 1'b0;
          w_incorrect_n = 1'b0;
          w_partial_n   = 1'b0;
          w_grade_n     = GRADE_NONE;
          w_timer_cur   = '0;
          w_eval        = 1'b1;
        end else begin
          w_stray_edge = |r_btn_edge;
        end
      end else if (r_win_fall) begin
        if (r_state == S_OPEN) begin
          w_valid_n   = 1'b1;
          w_partial_n = 1'b0;
          if (r_target_q == '0) begin
            w_correct_n = 1'b1;
            w_grade_n   = GRADE_PERFECT;
            w_combo_n   = w_combo_inc;
          end else begin
            w_incorrect_n = 1'b1;
            w_grade_n     = GRADE_MISS;
            w_combo_n     = '0;
          end
        end
        w_state_n    = S_IDLE;
        w_stray_edge = |r_btn_edge;
      end else if (r_state == S_OPEN) begin
        w_eval = 1'b1;
      end

      if (w_eval) begin
        w_timer_n   = (w_timer_cur == TIMER_MAX) ? TIMER_MAX : w_timer_cur + 1'b1;
        w_pressed_n = w_pressed_n | r_btn_edge;
        if (|(r_btn_edge & ~w_target_n)) begin
          w_state_n     = S_DONE;
          w_incorrect_n = 1'b1;
          w_correct_n   = 1'b0;
          w_partial_n   = 1'b0;
          w_grade_n     = GRADE_MISS;
          w_valid_n     = 1'b1;
          w_combo_n     = '0;
        end else if ((w_pressed_n == w_target_n) && (|w_target_n)) begin
          w_state_n   = S_DONE;
          w_correct_n = 1'b1;
          w_partial_n = 1'b0;
          w_grade_n   = ({1'b0, w_timer_cur} < PERF_LIM) ? GRADE_PERFECT : GRADE_GOOD;
          w_valid_n   = 1'b1;
          w_combo_n   = w_combo_inc;
        end else begin
          w_partial_n = (|w_pressed_n) && ((w_pressed_n & ~w_target_n) == '0) &&
                        (w_pressed_n != w_target_n);
        end
      end

      if (w_stray_edge) begin
        w_stray_n = 1'b1;
        w_combo_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_pressed     <= '0;
      r_target_q    <= '0;
      correct_hit   <= 1'b0;
      incorrect_hit <= 1'b0;
      partial       <= 1'b0;
      grade         <= GRADE_NONE;
      judge_valid   <= 1'b0;
      stray_press   <= 1'b0;
      combo         <= '0;
    end else begin
      r_state       <= w_state_n;
      r_timer       <= w_timer_n;
      r_pressed     <= w_pressed_n;
      r_target_q    <= w_target_n;
      correct_hit   <= w_correct_n;
      incorrect_hit <= w_incorrect_n;
      partial       <= w_partial_n;
      grade         <= w_grade_n;
      judge_valid   <= w_valid_n;
      stray_press   <= w_stray_n;
      combo         <= w_combo_n;
    end
  end

endmodule

// File: tb/tb_hit_judge_multi.sv
// Directed self-checking bench for hit_judge_multi (default parameters).
module tb_hit_judge_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       metronome_clk;
  logic [3:0] btn;
  logic [3:0] target;
  logic       game_en;
  logic       correct_hit, incorrect_hit, partial, judge_valid, stray_press;
  logic [1:0] grade;
  logic [7:0] combo;

  int tests = 0;
  int fails = 0;

  hit_judge_multi dut (
    .clk           (clk),
    .rst           (rst),
    .metronome_clk (metronome_clk),
    .btn           (btn),
    .target        (target),
    .game_en       (game_en),
    .correct_hit   (correct_hit),
    .incorrect_hit (incorrect_hit),
    .partial       (partial),
    .grade         (grade),
    .judge_valid   (judge_valid),
    .stray_press   (stray_press),
    .combo         (combo)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".correct"},   32'(correct_hit),   32'd0);
    chk({tag, ".incorrect"}, 32'(incorrect_hit), 32'd0);
    chk({tag, ".partial"},   32'(partial),       32'd0);
    chk({tag, ".grade"},     32'(grade),         32'd0);
    chk({tag, ".valid"},     32'(judge_valid),   32'd0);
    chk({tag, ".stray"},     32'(stray_press),   32'd0);
    chk({tag, ".combo"},     32'(combo),         32'd0);
  endtask

  initial begin
    rst = 1'b1; metronome_clk = 1'b0; btn = '0; target = '0; game_en = 1'b1;
    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(3);

    // Two-lane chord: lane0 at t=3, lane1 at t=6 -> PERFECT
    target = 4'b0011; metronome_clk = 1'b1;
    tick(3);
    btn = 4'b0001;
    tick(3);
    btn = 4'b0011;
    tick(1);
    chk("chord.partial_mid", 32'(partial), 32'd1);
    chk("chord.correct_mid", 32'(correct_hit), 32'd0);
    tick(2);
    chk("chord.valid_early", 32'(judge_valid), 32'd0);
    tick(1);
    chk("chord.correct", 32'(correct_hit), 32'd1);
    chk("chord.grade", 32'(grade), 32'd1);
    chk("chord.valid", 32'(judge_valid), 32'd1);
    chk("chord.partial_end", 32'(partial), 32'd0);
    chk("chord.combo", 32'(combo), 32'd1);
    tick(1);
    chk("chord.valid_pulse", 32'(judge_valid), 32'd0);
    chk("chord.correct_held", 32'(correct_hit), 32'd1);
    metronome_clk = 1'b0; btn = '0;
    tick(6);
    chk("close_done.valid", 32'(judge_valid), 32'd0);

    // t=15 is the last PERFECT timer value; flags held until the next window opens
    target = 4'b0001; metronome_clk = 1'b1;
    tick(3);
    chk("held.correct", 32'(correct_hit), 32'd1);
    tick(1);
    chk("open.clear_correct", 32'(correct_hit), 32'd0);
    chk("open.clear_grade", 32'(grade), 32'd0);
    tick(11);
    btn = 4'b0001;
    tick(4);
    chk("t15.correct", 32'(correct_hit), 32'd1);
    chk("t15.grade", 32'(grade), 32'd1);
    chk("t15.combo", 32'(combo), 32'd2);
    metronome_clk = 1'b0; btn = '0;
    tick(6);

    // Press at t=20 -> GOOD
    target = 4'b0001; metronome_clk = 1'b1;
    tick(20);
    btn = 4'b0001;
    tick(4);
    chk("t20.correct", 32'(correct_hit), 32'd1);
    chk("t20.grade", 32'(grade), 32'd2);
    chk("t20.combo", 32'(combo), 32'd3);
    metronome_clk = 1'b0; btn = '0;
    tick(6);

    // Completing lane plus wrong lane in one cycle -> incorrect; later press ignored
    target = 4'b0011; metronome_clk = 1'b1;
    tick(3);
    btn = 4'b0101;
    tick(4);
    chk("wrong.incorrect", 32'(incorrect_hit), 32'd1);
    chk("wrong.correct", 32'(correct_hit), 32'd0);
    chk("wrong.grade", 32'(grade), 32'd3);
    chk("wrong.valid", 32'(judge_valid), 32'd1);
    chk("wrong.combo", 32'(combo), 32'd0);
    btn = 4'b0111;
    tick(5);
    chk("frozen.incorrect", 32'(incorrect_hit), 32'd1);
    chk("frozen.correct", 32'(correct_hit), 32'd0);
    chk("frozen.valid", 32'(judge_valid), 32'd0);
    chk("frozen.grade", 32'(grade), 32'd3);
    metronome_clk = 1'b0; btn = '0;
    tick(6);

    // No press before close -> MISS at window fall
    target = 4'b0100; metronome_clk = 1'b1;
    tick(10);
    metronome_clk = 1'b0;
    tick(3);
    chk("miss.before_close", 32'(incorrect_hit), 32'd0);
    tick(1);
    chk("miss.incorrect", 32'(incorrect_hit), 32'd1);
    chk("miss.grade", 32'(grade), 32'd3);
    chk("miss.valid", 32'(judge_valid), 32'd1);
    tick(1);
    chk("miss.valid_pulse", 32'(judge_valid), 32'd0);
    tick(4);

    // Rest beat with no press -> PERFECT at close
    target = 4'b0000; metronome_clk = 1'b1;
    tick(10);
    metronome_clk = 1'b0;
    tick(4);
    chk("rest.correct", 32'(correct_hit), 32'd1);
    chk("rest.incorrect", 32'(incorrect_hit), 32'd0);
    chk("rest.grade", 32'(grade), 32'd1);
    chk("rest.valid", 32'(judge_valid), 32'd1);
    chk("rest.combo", 32'(combo), 32'd1);
    tick(4);

    // Paused: closed-window press is discarded, no stray
    game_en = 1'b0; btn = 4'b0001;
    tick(6);
    chk("pause.stray", 32'(stray_press), 32'd0);
    chk("pause.combo", 32'(combo), 32'd1);
    btn = '0;
    tick(5);
    game_en = 1'b1;

    // Closed-window press -> stray pulse, combo cleared, verdict untouched
    btn = 4'b0010;
    tick(4);
    chk("stray.pulse", 32'(stray_press), 32'd1);
    chk("stray.combo", 32'(combo), 32'd0);
    chk("stray.correct_kept", 32'(correct_hit), 32'd1);
    tick(1);
    chk("stray.pulse_end", 32'(stray_press), 32'd0);
    btn = '0;
    tick(4);

    // Build combo to 5
    for (int i = 0; i < 5; i++) begin
      target = 4'b0001; metronome_clk = 1'b1;
      tick(3);
      btn = 4'b0001;
      tick(4);
      metronome_clk = 1'b0; btn = '0;
      tick(6);
    end
    chk("combo5", 32'(combo), 32'd5);

    // Async reset mid-window
    target = 4'b0011; metronome_clk = 1'b1;
    tick(5);
    btn = 4'b0001;
    tick(5);
    chk("pre_reset.partial", 32'(partial), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick(2);
    rst = 1'b0; metronome_clk = 1'b0; btn = '0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
